wb_cdb_arbiter: RTL and testbench

- Consumer end of the functional-unit result interface.
- Accepts completed results from the ALU, branch and memory units, buffers them in one flushable FIFO per source, and broadcasts one result per cycle on the common data bus (CDB).
- The CDB feeds the PRF write port, RS wakeup and ROB completion.
- Arbitration is oldest-first by ROB age. Entries younger than a branch mispredict are squashed.

---
 rtl/wb_pkg.sv | 38 +++
 rtl/wb_fifo.sv | 118 +++++++++++
 rtl/wb_cdb_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_cdb_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback / common-data-bus slice.
//
// Contents:
//   WB_TAG_W, WB_PREG_W : entry field widths (ROB tag and physical register index)
//   SRC_ALU/SRC_B/SRC_MEM : source encodings driven on cdb_src
//   wb_entry_t          : one buffered functional-unit result
//   rob_age()           : distance of a tag from the ROB head (smaller = older)
//   rob_younger()       : true when tag a is younger than tag b
package wb_pkg;

  localparam int WB_TAG_W  = 5;
  localparam int WB_PREG_W = 7;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_B   = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;

  typedef struct packed {
    logic                 valid;
    logic [WB_TAG_W-1:0]  rob_tag;
    logic [WB_PREG_W-1:0] pd;
    logic                 has_dest;
    logic [31:0]          result;
  } wb_entry_t;

  // Modular distance from the head; the subtraction wraps at 2^WB_TAG_W.
  function automatic logic [WB_TAG_W-1:0] rob_age(input logic [WB_TAG_W-1:0] tag,
                                                  input logic [WB_TAG_W-1:0] head);
    return tag - head;
  endfunction

  function automatic logic rob_younger(input logic [WB_TAG_W-1:0] a,
                                       input logic [WB_TAG_W-1:0] b,
                                       input logic [WB_TAG_W-1:0] head);
    return rob_age(a, head) > rob_age(b, head);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Flushable per-source result FIFO.
//
// Every slot carries its own valid bit so a mispredict can squash entries in
// place without disturbing pointers. Squashed slots reaching the head are
// reclaimed one per cycle without being offered to the CDB.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   rob_head            : oldest ROB tag, age reference for squashing
//   mispredict          : flush request
//   mispredict_tag      : tag of the mispredicted branch
//   in_entry            : incoming result (in_entry.valid = push request)
//   pop                 : head was granted the CDB this cycle
//   head_entry          : current head slot contents
//   head_eligible       : head is valid and not being killed this cycle
//   stall               : registered backpressure, free slots <= STALL_THRESH
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STALL_THRESH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WB_TAG_W-1:0] rob_head,
  input  logic                mispredict,
  input  logic [WB_TAG_W-1:0] mispredict_tag,
  input  wb_entry_t           in_entry,
  input  logic                pop,
  output wb_entry_t           head_entry,
  output logic                head_eligible,
  output logic                stall
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        slots [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [DEPTH-1:0] kill;
  logic             kill_in;
  logic             full;
  logic             push_ok;
  logic             pop_ok;
  logic             reclaim;

  // Kill mask: anything strictly younger than the mispredicted branch dies.
  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = mispredict && rob_younger(slots[i].rob_tag, mispredict_tag, rob_head);
    end
  end

  assign kill_in       = mispredict && rob_younger(in_entry.rob_tag, mispredict_tag, rob_head);
  assign full          = (count == CNT_W'(DEPTH));
  assign push_ok       = in_entry.valid && !full;
  assign head_entry    = slots[head];
  assign head_eligible = (count != '0) && slots[head].valid && !kill[head];
  assign pop_ok        = pop && head_eligible;
  // A hole at the head is never eligible, so pop and reclaim are exclusive.
  assign reclaim       = (count != '0) && !slots[head].valid;

  // Occupancy after this cycle's push and pop/reclaim.
  always_comb begin
    count_next = count;
    if (push_ok) begin
      count_next = count_next + 1'b1;
    end
    if (pop_ok || reclaim) begin
      count_next = count_next - 1'b1;
    end
  end

  // Storage, pointers, count and registered stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      stall <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill[i]) begin
          slots[i].valid <= 1'b0;
        end
      end
      // Clearing the departing slot keeps valid bits confined to occupied slots.
      if (pop_ok || reclaim) begin
        slots[head].valid <= 1'b0;
        head              <= head + 1'b1;
      end
      // Squashed arrivals still take a slot so ordering stays simple; they are
      // reclaimed as holes later.
      if (push_ok) begin
        slots[tail] <= '{valid:    !kill_in,
                          rob_tag:  in_entry.rob_tag,
                          pd:       in_entry.pd,
                          has_dest: in_entry.has_dest,
                          result:   in_entry.result};
        tail        <= tail + 1'b1;
      end
      count <= count_next;
      stall <= (int'(DEPTH) - int'(count_next)) <= STALL_THRESH;
    end
  end

  // Upstream must honour stall; a push into a full FIFO is a protocol error.
  assert property (@(posedge clk) disable iff (reset) !(in_entry.valid && full))
    else $error("wb_fifo: push into full FIFO");

endmodule

// File: rtl/wb_cdb_arbiter.sv
// Writeback arbiter driving the common data bus.
//
// Buffers ALU, branch and memory results in one flushable FIFO each and
// broadcasts the oldest eligible head (by ROB age) every cycle.
//
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   rob_head                         : oldest ROB tag, age reference
//   mispredict, mispredict_tag       : flush younger-than-branch results
//   {alu,b,mem}_valid/_rob_tag/_pd/_has_dest/_result : incoming results
//   {alu,b,mem}_stall                : registered backpressure to each RS
//   cdb_valid/_src/_rob_tag/_pd/_has_dest/_result    : broadcast (combinational)
module wb_cdb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int TAG_W        = WB_TAG_W,
  parameter int PREG_W       = WB_PREG_W,
  parameter int STALL_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TAG_W-1:0]  rob_head,
  input  logic              mispredict,
  input  logic [TAG_W-1:0]  mispredict_tag,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_rob_tag,
  input  logic [PREG_W-1:0] alu_pd,
  input  logic              alu_has_dest,
  input  logic [31:0]       alu_result,
  input  logic              b_valid,
  input  logic [TAG_W-1:0]  b_rob_tag,
  input  logic [PREG_W-1:0] b_pd,
  input  logic              b_has_dest,
  input  logic [31:0]       b_result,
  input  logic              mem_valid,
  input  logic [TAG_W-1:0]  mem_rob_tag,
  input  logic [PREG_W-1:0] mem_pd,
  input  logic              mem_has_dest,
  input  logic [31:0]       mem_result,
  output logic              alu_stall,
  output logic              b_stall,
  output logic              mem_stall,
  output logic              cdb_valid,
  output logic [1:0]        cdb_src,
  output logic [TAG_W-1:0]  cdb_rob_tag,
  output logic [PREG_W-1:0] cdb_pd,
  output logic              cdb_has_dest,
  output logic [31:0]       cdb_result
);

  wb_entry_t         in_e   [3];
  wb_entry_t         head_e [3];
  logic [2:0]        elig;
  logic [2:0]        pop;
  logic [2:0]        stall;
  logic              grant_valid;
  logic [1:0]        grant_src;
  logic [TAG_W-1:0]  best_age;
  wb_entry_t         sel;

  // Pack each source's result bus into the common entry format.
  always_comb begin
    in_e[SRC_ALU] = '{valid: alu_valid, rob_tag: alu_rob_tag, pd: alu_pd,
                      has_dest: alu_has_dest, result: alu_result};
    in_e[SRC_B]   = '{valid: b_valid, rob_tag: b_rob_tag, pd: b_pd,
                      has_dest: b_has_dest, result: b_result};
    in_e[SRC_MEM] = '{valid: mem_valid, rob_tag: mem_rob_tag, pd: mem_pd,
                      has_dest: mem_has_dest, result: mem_result};
  end

  for (genvar g = 0; g < 3; g++) begin : g_fifo
    wb_fifo #(
      .DEPTH        (FIFO_DEPTH),
      .STALL_THRESH (STALL_THRESH)
    ) u_fifo (
      .clk            (clk),
      .reset          (reset),
      .rob_head       (rob_head),
      .mispredict     (mispredict),
      .mispredict_tag (mispredict_tag),
      .in_entry       (in_e[g]),
      .pop            (pop[g]),
      .head_entry     (head_e[g]),
      .head_eligible  (elig[g]),
      .stall          (stall[g])
    );
  end

  assign alu_stall = stall[SRC_ALU];
  assign b_stall   = stall[SRC_B];
  assign mem_stall = stall[SRC_MEM];

  // Oldest-first grant. Tags are unique, so the strict compare never ties;
  // sel stays zero when nothing is eligible, which zeroes the data outputs.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_ALU;
    best_age    = '0;
    sel         = '0;
    pop         = '0;
    for (int i = 0; i < 3; i++) begin
      if (elig[i] && (!grant_valid || rob_age(head_e[i].rob_tag, rob_head) < best_age)) begin
        grant_valid = 1'b1;
        grant_src   = 2'(i);
        best_age    = rob_age(head_e[i].rob_tag, rob_head);
        sel         = head_e[i];
      end
    end
    for (int i = 0; i < 3; i++) begin
      pop[i] = grant_valid && (grant_src == 2'(i));
    end
  end

  assign cdb_valid    = grant_valid && sel.valid;
  assign cdb_src      = grant_src;
  assign cdb_rob_tag  = sel.rob_tag;
  assign cdb_pd       = sel.pd;
  assign cdb_has_dest = sel.has_dest;
  assign cdb_result   = sel.result;

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Self-checking bench for wb_cdb_arbiter. Expected broadcasts are inserted
// into an age-ordered queue when stimulus is driven; a negedge monitor pops
// and compares every CDB broadcast. Squashed or reset-discarded results are
// never queued, so their appearance on the CDB is reported.
module tb_wb_cdb_arbiter;
  import wb_pkg::*;

  typedef struct packed {
    logic [1:0]  src;
    logic [4:0]  tag;
    logic [6:0]  pd;
    logic        has_dest;
    logic [31:0] result;
  } bcast_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rob_head;
  logic        mispredict;
  logic [4:0]  mispredict_tag;
  logic        alu_valid, b_valid, mem_valid;
  logic [4:0]  alu_rob_tag, b_rob_tag, mem_rob_tag;
  logic [6:0]  alu_pd, b_pd, mem_pd;
  logic        alu_has_dest, b_has_dest, mem_has_dest;
  logic [31:0] alu_result, b_result, mem_result;
  logic        alu_stall, b_stall, mem_stall;
  logic        cdb_valid;
  logic [1:0]  cdb_src;
  logic [4:0]  cdb_rob_tag;
  logic [6:0]  cdb_pd;
  logic        cdb_has_dest;
  logic [31:0] cdb_result;

  int     tests_run    = 0;
  int     tests_failed = 0;
  bcast_t exp_q [$];
  bcast_t mon_got;
  bcast_t mon_exp;

  wb_cdb_arbiter dut (
    .clk(clk), .reset(reset), .rob_head(rob_head),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .alu_valid(alu_valid), .alu_rob_tag(alu_rob_tag), .alu_pd(alu_pd),
    .alu_has_dest(alu_has_dest), .alu_result(alu_result),
    .b_valid(b_valid), .b_rob_tag(b_rob_tag), .b_pd(b_pd),
    .b_has_dest(b_has_dest), .b_result(b_result),
    .mem_valid(mem_valid), .mem_rob_tag(mem_rob_tag), .mem_pd(mem_pd),
    .mem_has_dest(mem_has_dest), .mem_result(mem_result),
    .alu_stall(alu_stall), .b_stall(b_stall), .mem_stall(mem_stall),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob_tag(cdb_rob_tag),
    .cdb_pd(cdb_pd), .cdb_has_dest(cdb_has_dest), .cdb_result(cdb_result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Keep the expected queue ordered oldest-first relative to the current head.
  task automatic expectInsert(input bcast_t e);
    int pos = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rob_age(exp_q[i].tag, rob_head) > rob_age(e.tag, rob_head)) begin
        pos = i;
        break;
      end
    end
    exp_q.insert(pos, e);
  endtask

  task automatic applyStimulus(input logic [1:0] src, input logic [4:0] tag,
                               input logic [6:0] pd, input logic [31:0] result,
                               input bit expect_bcast);
    case (src)
      SRC_ALU: begin
        alu_valid = 1'b1; alu_rob_tag = tag; alu_pd = pd;
        alu_has_dest = 1'b1; alu_result = result;
      end
      SRC_B: begin
        b_valid = 1'b1; b_rob_tag = tag; b_pd = pd;
        b_has_dest = 1'b1; b_result = result;
      end
      default: begin
        mem_valid = 1'b1; mem_rob_tag = tag; mem_pd = pd;
        mem_has_dest = 1'b1; mem_result = result;
      end
    endcase
    if (expect_bcast) begin
      expectInsert('{src: src, tag: tag, pd: pd, has_dest: 1'b1, result: result});
    end
  endtask

  task automatic clearInputs();
    alu_valid = 1'b0; b_valid = 1'b0; mem_valid = 1'b0;
    alu_rob_tag = '0; b_rob_tag = '0; mem_rob_tag = '0;
    alu_pd = '0; b_pd = '0; mem_pd = '0;
    alu_has_dest = 1'b0; b_has_dest = 1'b0; mem_has_dest = 1'b0;
    alu_result = '0; b_result = '0; mem_result = '0;
    mispredict = 1'b0; mispredict_tag = '0;
  endtask

  // Advance to the start of the next cycle; inputs default to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic drainWait(input string tag);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      tick();
    end
    checkOutput(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) tick();
  endtask

  // Scoreboard monitor: every broadcast outside reset must match the queue front.
  always @(negedge clk) begin
    if (!reset && cdb_valid) begin
      mon_got = {cdb_src, cdb_rob_tag, cdb_pd, cdb_has_dest, cdb_result};
      checkOutput("bcast_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        checkOutput("bcast_data", 64'(mon_got), 64'(mon_exp));
      end
    end
  end

  initial begin
    clearInputs();
    rob_head = '0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    checkOutput("rst_cdb_data", 64'({cdb_src, cdb_rob_tag, cdb_pd, cdb_has_dest, cdb_result}), 64'd0);
    checkOutput("rst_stalls", 64'({alu_stall, b_stall, mem_stall}), 64'd0);

    // Single ALU result, 1-cycle latency.
    tick();
    applyStimulus(SRC_ALU, 5'd4, 7'd9, 32'hDEAD, 1'b1);
    tick();
    @(negedge clk);
    checkOutput("t1_valid", 64'(cdb_valid), 64'd1);
    checkOutput("t1_src", 64'(cdb_src), 64'd0);
    checkOutput("t1_tag", 64'(cdb_rob_tag), 64'd4);
    checkOutput("t1_pd", 64'(cdb_pd), 64'd9);
    checkOutput("t1_result", 64'(cdb_result), 64'hDEAD);
    tick();
    @(negedge clk);
    checkOutput("t1_idle", 64'(cdb_valid), 64'd0);
    drainWait("t1_drain");

    // Three sources in one cycle, oldest-first.
    rob_head = 5'd0;
    applyStimulus(SRC_ALU, 5'd5, 7'd20, 32'h5555, 1'b1);
    applyStimulus(SRC_B,   5'd3, 7'd21, 32'h3333, 1'b1);
    applyStimulus(SRC_MEM, 5'd9, 7'd22, 32'h9999, 1'b1);
    tick();
    @(negedge clk);
    checkOutput("t2_first_src", 64'(cdb_src), 64'd1);
    drainWait("t2_drain");

    // Age wraps around the ROB.
    rob_head = 5'd30;
    applyStimulus(SRC_ALU, 5'd1,  7'd30, 32'h0001, 1'b1);
    applyStimulus(SRC_MEM, 5'd31, 7'd31, 32'h001F, 1'b1);
    tick();
    @(negedge clk);
    checkOutput("t3_wrap_first", 64'(cdb_rob_tag), 64'd31);
    drainWait("t3_drain");

    // Mispredict flush of buffered and incoming younger results.
    rob_head = 5'd0;
    applyStimulus(SRC_B,   5'd0, 7'd40, 32'h100, 1'b1);
    applyStimulus(SRC_MEM, 5'd1, 7'd41, 32'h101, 1'b1);
    applyStimulus(SRC_ALU, 5'd2, 7'd42, 32'h102, 1'b1);
    tick();
    applyStimulus(SRC_ALU, 5'd6, 7'd43, 32'h106, 1'b0);
    tick();
    applyStimulus(SRC_ALU, 5'd8, 7'd44, 32'h108, 1'b0);
    @(negedge clk);
    checkOutput("t4_alu_stall_hi", 64'(alu_stall), 64'd1);
    tick();
    mispredict     = 1'b1;
    mispredict_tag = 5'd5;
    applyStimulus(SRC_MEM, 5'd7, 7'd45, 32'h107, 1'b0);
    applyStimulus(SRC_B,   5'd4, 7'd46, 32'h104, 1'b1);
    @(negedge clk);
    checkOutput("t4_flush_head", 64'(cdb_rob_tag), 64'd2);
    tick();
    @(negedge clk);
    checkOutput("t4_alu_stall_c5", 64'(alu_stall), 64'd1);
    checkOutput("t4_survivor", 64'(cdb_rob_tag), 64'd4);
    tick();
    @(negedge clk);
    checkOutput("t4_alu_stall_lo", 64'(alu_stall), 64'd0);
    checkOutput("t4_idle", 64'(cdb_valid), 64'd0);
    tick();
    @(negedge clk);
    checkOutput("t4_idle_after", 64'(cdb_valid), 64'd0);
    drainWait("t4_drain");

    // Mem backpressure while older ALU/branch results hold the CDB.
    rob_head = 5'd0;
    applyStimulus(SRC_ALU, 5'd0, 7'd50, 32'h200, 1'b1);
    applyStimulus(SRC_B,   5'd1, 7'd51, 32'h201, 1'b1);
    tick();
    applyStimulus(SRC_ALU, 5'd2, 7'd52, 32'h202, 1'b1);
    applyStimulus(SRC_B,   5'd3, 7'd53, 32'h203, 1'b1);
    applyStimulus(SRC_MEM, 5'd8, 7'd58, 32'h208, 1'b1);
    tick();
    applyStimulus(SRC_ALU, 5'd4, 7'd54, 32'h204, 1'b1);
    applyStimulus(SRC_B,   5'd5, 7'd55, 32'h205, 1'b1);
    applyStimulus(SRC_MEM, 5'd9, 7'd59, 32'h209, 1'b1);
    @(negedge clk);
    checkOutput("t5_mem_stall_c3", 64'(mem_stall), 64'd0);
    tick();
    applyStimulus(SRC_MEM, 5'd10, 7'd60, 32'h20A, 1'b1);
    @(negedge clk);
    checkOutput("t5_mem_stall_c4", 64'(mem_stall), 64'd1);
    tick();
    applyStimulus(SRC_MEM, 5'd11, 7'd61, 32'h20B, 1'b1);
    tick();
    @(negedge clk);
    checkOutput("t5_mem_stall_c6", 64'(mem_stall), 64'd1);
    drainWait("t5_drain");
    checkOutput("t5_mem_stall_end", 64'(mem_stall), 64'd0);

    // Reset with entries buffered discards them.
    rob_head = 5'd0;
    applyStimulus(SRC_ALU, 5'd10, 7'd70, 32'h300, 1'b0);
    applyStimulus(SRC_B,   5'd11, 7'd71, 32'h301, 1'b0);
    applyStimulus(SRC_MEM, 5'd12, 7'd72, 32'h302, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(SRC_ALU, 5'd20, 7'd3, 32'h1234, 1'b1);
    @(negedge clk);
    checkOutput("t6_post_rst_valid", 64'(cdb_valid), 64'd0);
    checkOutput("t6_post_rst_stalls", 64'({alu_stall, b_stall, mem_stall}), 64'd0);
    tick();
    @(negedge clk);
    checkOutput("t6_new_valid", 64'(cdb_valid), 64'd1);
    checkOutput("t6_new_tag", 64'(cdb_rob_tag), 64'd20);
    drainWait("t6_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
